// File: rtl/frame_seq_pkg.sv
// Shared types for the frame sequencer: calc and stream state
// enums, the line-buffer bank index, default geometry and a width helper.
package frame_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_MASK,
    S_CALC,
    S_HANDOFF
  } calc_state_t;

  typedef enum logic {
    R_IDLE,
    R_STREAM
  } stream_state_t;

  typedef logic bank_t;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_sequencer_line_buffer.sv
// line_buffer_2bank: two WIDTH x DW simple dual-port banks.
// Ports: write (we, wr_bank, wr_addr, wr_data); read (rd_bank, rd_addr) -> rd_data one cycle later.
module line_buffer_2bank
  import frame_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DW    = 10,
  parameter int AW    = idx_w(DEF_WIDTH)
) (
  input  logic          clk,
  input  logic          we,
  input  bank_t         wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  bank_t         rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] bank0 [WIDTH];
  logic [DW-1:0] bank1 [WIDTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we && !wr_bank) bank0[wr_addr] <= wr_data;
    if (we && wr_bank)  bank1[wr_addr] <= wr_data;
    rd_data_q <= rd_bank ? bank1[rd_addr] : bank0[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: issues line starts to the engine, captures pixels into a
// ping-pong line buffer, streams finished lines out (px_*), latches cfg per frame.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_HEIGHT,
  parameter int DEPTH_W       = 10,
  parameter int WORD_LENGTH   = 32,
  parameter int START_MASK    = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             cfg_valid,
  input  logic [7:0]                       cfg_zoom,
  input  logic [WORD_LENGTH-1:0]           cfg_real_center,
  input  logic [WORD_LENGTH-1:0]           cfg_imag_center,
  output logic [7:0]                       cur_zoom,
  output logic [WORD_LENGTH-1:0]           cur_real_center,
  output logic [WORD_LENGTH-1:0]           cur_imag_center,
  output logic                             eng_start,
  input  logic                             eng_done,
  input  logic                             eng_we,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]  eng_addr,
  input  logic [DEPTH_W-1:0]               eng_depth,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] cur_y,
  output logic                             px_valid,
  input  logic                             px_ready,
  output logic [DEPTH_W-1:0]               px_data,
  output logic                             px_last,
  output logic                             px_sof,
  output logic                             frame_done
);

  localparam int XW = idx_w(SCREEN_WIDTH);
  localparam int YW = idx_w(SCREEN_HEIGHT);
  localparam int MW = idx_w(START_MASK);
  localparam int WL = WORD_LENGTH;
  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_HEIGHT - 1);
  localparam logic [MW-1:0] M_LAST = MW'(START_MASK - 1);

  // calc side
  calc_state_t   cs_q, cs_d;
  logic [MW-1:0] mask_q, mask_d;
  logic [YW-1:0] y_q, y_d;
  bank_t         wr_bank_q, wr_bank_d;
  logic [1:0]    full_q, full_d;
  logic [1:0]    sof_bank_q, sof_bank_d;
  logic [1:0]    eof_bank_q, eof_bank_d;
  logic          start_q, start_d;
  logic [7:0]    zoom_q, zoom_d;
  logic [WL-1:0] re_q, re_d;
  logic [WL-1:0] im_q, im_d;
  logic          pend_q, pend_d;
  logic [7:0]    pzoom_q, pzoom_d;
  logic [WL-1:0] pre_q, pre_d;
  logic [WL-1:0] pim_q, pim_d;

  // stream side
  stream_state_t    rs_q, rs_d;
  bank_t            rd_bank_q, rd_bank_d;
  logic [XW-1:0]    rd_x_q, rd_x_d;
  logic             iss_done_q, iss_done_d;
  logic             infl_q, infl_d;
  logic             infl_last_q, infl_last_d;
  logic             infl_sof_q, infl_sof_d;
  logic [DEPTH_W-1:0] f_data_q [2];
  logic [DEPTH_W-1:0] f_data_d [2];
  logic [1:0]       f_last_q, f_last_d;
  logic [1:0]       f_sof_q, f_sof_d;
  logic             f_wp_q, f_wp_d;
  logic             f_rp_q, f_rp_d;
  logic [1:0]       f_cnt_q, f_cnt_d;

  logic               wr_en;
  logic [DEPTH_W-1:0] rd_data;
  logic               pop;
  logic               free_now;
  logic               stream_idle;
  bank_t              other;
  logic               other_free;
  logic [1:0]         set_full;
  logic [1:0]         clr_full;
  logic               issue;
  logic [2:0]         occ_after;

  assign wr_en = eng_we
              && (cs_q == S_START || cs_q == S_MASK || cs_q == S_CALC)
              && ({1'b0, eng_addr} <= {1'b0, X_LAST});

  line_buffer_2bank #(
    .WIDTH (SCREEN_WIDTH),
    .DW    (DEPTH_W),
    .AW    (XW)
  ) u_lbuf (
    .clk     (clk),
    .we      (wr_en),
    .wr_bank (wr_bank_q),
    .wr_addr (eng_addr),
    .wr_data (eng_depth),
    .rd_bank (rd_bank_q),
    .rd_addr (rd_x_q),
    .rd_data (rd_data)
  );

  assign pop         = (f_cnt_q != 2'd0) && px_ready;
  assign free_now    = pop && f_last_q[f_rp_q];
  assign stream_idle = (rs_q == R_IDLE) && (full_q == 2'b00);
  assign other       = ~wr_bank_q;
  // a bank released by the reader this cycle counts as free
  assign other_free  = !full_q[other]
                    || (free_now && rd_bank_q == other);

  always_comb begin
    cs_d       = cs_q;
    mask_d     = mask_q;
    y_d        = y_q;
    wr_bank_d  = wr_bank_q;
    set_full   = 2'b00;
    sof_bank_d = sof_bank_q;
    eof_bank_d = eof_bank_q;
    zoom_d     = zoom_q;
    re_d       = re_q;
    im_d       = im_q;
    pend_d     = pend_q | cfg_valid;
    pzoom_d    = cfg_valid ? cfg_zoom : pzoom_q;
    pre_d      = cfg_valid ? cfg_real_center : pre_q;
    pim_d      = cfg_valid ? cfg_imag_center : pim_q;
    unique case (cs_q)
      S_IDLE: begin
        if (enable && stream_idle) begin
          if (pend_q) begin
            zoom_d = pzoom_q;
            re_d   = pre_q;
            im_d   = pim_q;
          end
          // a same-cycle cfg stays pending
          pend_d = cfg_valid;
          y_d    = '0;
          cs_d   = S_START;
        end
      end
      S_START: begin
        mask_d = '0;
        cs_d   = S_MASK;
      end
      S_MASK: begin
        if (mask_q == M_LAST) cs_d = S_CALC;
        else mask_d = mask_q + 1'b1;
      end
      S_CALC: begin
        if (eng_done) cs_d = S_HANDOFF;
      end
      S_HANDOFF: begin
        if (other_free) begin
          set_full[wr_bank_q]   = 1'b1;
          sof_bank_d[wr_bank_q] = (y_q == '0);
          eof_bank_d[wr_bank_q] = (y_q == Y_LAST);
          wr_bank_d = other;
          if (y_q == Y_LAST) begin
            cs_d = S_IDLE;
          end else begin
            y_d  = y_q + 1'b1;
            cs_d = S_START;
          end
        end
      end
      default: cs_d = S_IDLE;
    endcase
    start_d = (cs_d == S_START);
  end

  always_comb begin
    rs_d        = rs_q;
    rd_bank_d   = rd_bank_q;
    rd_x_d      = rd_x_q;
    iss_done_d  = iss_done_q;
    issue       = 1'b0;
    clr_full    = 2'b00;
    // occupancy (fifo + read in flight) once this cycle's pop is done
    occ_after   = {1'b0, f_cnt_q} + {2'b0, infl_q} - {2'b0, pop};
    unique case (rs_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rs_d       = R_STREAM;
          rd_x_d     = '0;
          iss_done_d = 1'b0;
        end
      end
      R_STREAM: begin
        if (!iss_done_q && occ_after < 3'd2) begin
          issue = 1'b1;
          if (rd_x_q == X_LAST) iss_done_d = 1'b1;
          else rd_x_d = rd_x_q + 1'b1;
        end
        if (free_now) begin
          clr_full[rd_bank_q] = 1'b1;
          rs_d      = R_IDLE;
          rd_bank_d = ~rd_bank_q;
        end
      end
      default: rs_d = R_IDLE;
    endcase
    full_d      = (full_q & ~clr_full) | set_full;
    infl_d      = issue;
    infl_last_d = (rd_x_q == X_LAST);
    infl_sof_d  = (rd_x_q == '0) && sof_bank_q[rd_bank_q];
    f_data_d    = f_data_q;
    f_last_d    = f_last_q;
    f_sof_d     = f_sof_q;
    f_wp_d      = f_wp_q;
    f_rp_d      = f_rp_q;
    if (infl_q) begin
      f_data_d[f_wp_q] = rd_data;
      f_last_d[f_wp_q] = infl_last_q;
      f_sof_d[f_wp_q]  = infl_sof_q;
      f_wp_d           = ~f_wp_q;
    end
    if (pop) f_rp_d = ~f_rp_q;
    f_cnt_d = f_cnt_q + {1'b0, infl_q} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q        <= S_IDLE;
      mask_q      <= '0;
      y_q         <= '0;
      wr_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      sof_bank_q  <= 2'b00;
      eof_bank_q  <= 2'b00;
      start_q     <= 1'b0;
      zoom_q      <= '0;
      re_q        <= '0;
      im_q        <= '0;
      pend_q      <= 1'b0;
      pzoom_q     <= '0;
      pre_q       <= '0;
      pim_q       <= '0;
      rs_q        <= R_IDLE;
      rd_bank_q   <= 1'b0;
      rd_x_q      <= '0;
      iss_done_q  <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_sof_q  <= 1'b0;
      f_data_q    <= '{default: '0};
      f_last_q    <= 2'b00;
      f_sof_q     <= 2'b00;
      f_wp_q      <= 1'b0;
      f_rp_q      <= 1'b0;
      f_cnt_q     <= 2'd0;
    end else begin
      cs_q        <= cs_d;
      mask_q      <= mask_d;
      y_q         <= y_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      sof_bank_q  <= sof_bank_d;
      eof_bank_q  <= eof_bank_d;
      start_q     <= start_d;
      zoom_q      <= zoom_d;
      re_q        <= re_d;
      im_q        <= im_d;
      pend_q      <= pend_d;
      pzoom_q     <= pzoom_d;
      pre_q       <= pre_d;
      pim_q       <= pim_d;
      rs_q        <= rs_d;
      rd_bank_q   <= rd_bank_d;
      rd_x_q      <= rd_x_d;
      iss_done_q  <= iss_done_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      infl_sof_q  <= infl_sof_d;
      f_data_q    <= f_data_d;
      f_last_q    <= f_last_d;
      f_sof_q     <= f_sof_d;
      f_wp_q      <= f_wp_d;
      f_rp_q      <= f_rp_d;
      f_cnt_q     <= f_cnt_d;
    end
  end

  assign eng_start       = start_q;
  assign cur_y           = y_q;
  assign cur_zoom        = zoom_q;
  assign cur_real_center = re_q;
  assign cur_imag_center = im_q;
  assign px_valid        = (f_cnt_q != 2'd0);
  assign px_data         = px_valid ? f_data_q[f_rp_q] : '0;
  assign px_last         = px_valid && f_last_q[f_rp_q];
  assign px_sof          = px_valid && f_sof_q[f_rp_q];
  assign frame_done      = free_now && eof_bank_q[rd_bank_q];

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: engine model feeds a scoreboard queue,
// stream monitor pops and compares each accepted beat.
module tb_frame_sequencer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 10;
  localparam int WL = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [7:0]    cfg_zoom = '0;
  logic [WL-1:0] cfg_real_center = '0;
  logic [WL-1:0] cfg_imag_center = '0;
  logic [7:0]    cur_zoom;
  logic [WL-1:0] cur_real_center;
  logic [WL-1:0] cur_imag_center;
  logic          eng_start;
  logic          eng_done = 1'b0;
  logic          eng_we = 1'b0;
  logic [2:0]    eng_addr = '0;
  logic [DW-1:0] eng_depth = '0;
  logic [1:0]    cur_y;
  logic          px_valid;
  logic          px_ready = 1'b0;
  logic [DW-1:0] px_data;
  logic          px_last;
  logic          px_sof;
  logic          frame_done;

  frame_sequencer #(
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H),
    .DEPTH_W       (DW),
    .WORD_LENGTH   (WL),
    .START_MASK    (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .cfg_valid       (cfg_valid),
    .cfg_zoom        (cfg_zoom),
    .cfg_real_center (cfg_real_center),
    .cfg_imag_center (cfg_imag_center),
    .cur_zoom        (cur_zoom),
    .cur_real_center (cur_real_center),
    .cur_imag_center (cur_imag_center),
    .eng_start       (eng_start),
    .eng_done        (eng_done),
    .eng_we          (eng_we),
    .eng_addr        (eng_addr),
    .eng_depth       (eng_depth),
    .cur_y           (cur_y),
    .px_valid        (px_valid),
    .px_ready        (px_ready),
    .px_data         (px_data),
    .px_last         (px_last),
    .px_sof          (px_sof),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {eof, sof, last, data}
  logic [12:0] exp_q [$];
  bit          abort = 1'b0;
  int          ey = 0;

  // engine: done stays stale for 3 cycles after start, then 8 writes,
  // done rises 5 cycles after the last write
  initial begin
    forever begin
      @(negedge clk);
      if (eng_start && !reset) begin : line
        int y;
        y  = ey;
        ey = (ey + 1) % H;
        repeat (3) @(negedge clk);
        eng_done = 1'b0;
        for (int x = 0; x < W; x++) begin
          eng_we    = 1'b1;
          eng_addr  = x[2:0];
          eng_depth = 10'(16 * y + x);
          if (!abort)
            exp_q.push_back({(y == H-1) && (x == W-1), (y == 0) && (x == 0),
                             (x == W-1), 10'(16 * y + x)});
          @(negedge clk);
        end
        eng_we = 1'b0;
        repeat (4) @(negedge clk);
        eng_done = 1'b1;
      end
    end
  end

  int rdy_mode = 1;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       px_ready = 1'b0;
        1:       px_ready = 1'b1;
        default: px_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  int beats = 0;
  int starts = 0;
  int frames = 0;
  int sofs = 0;
  int lasts = 0;
  logic          held = 1'b0;
  logic [DW-1:0] hd = '0;
  logic [12:0]   e;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (eng_start) starts++;
        if (held) begin
          check("hold_valid", px_valid, 1);
          check("hold_data", px_data, hd);
        end
        if (px_valid && px_ready) begin
          beats++;
          if (exp_q.size() == 0) begin
            check("sb_underflow", px_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("px_data", px_data, e[9:0]);
            check("px_last", px_last, e[10]);
            check("px_sof", px_sof, e[11]);
            check("frame_done", frame_done, e[12]);
          end
          if (px_sof) sofs++;
          if (px_last) lasts++;
        end else begin
          check("frame_done_idle", frame_done, 0);
        end
        if (frame_done) frames++;
        held = px_valid && !px_ready;
        hd   = px_data;
      end
    end
  end

  task automatic wait_starts(int n, int budget, string tag);
    int c = 0;
    while (starts < n && c < budget) begin
      tick();
      c++;
    end
    check(tag, starts, n);
  endtask

  task automatic wait_frames(int n, int budget, string tag);
    int c = 0;
    while (frames < n && c < budget) begin
      tick();
      c++;
    end
    check(tag, frames, n);
  endtask

  task automatic check_zero(string p);
    check({p, "_px_valid"}, px_valid, 0);
    check({p, "_eng_start"}, eng_start, 0);
    check({p, "_frame_done"}, frame_done, 0);
    check({p, "_px_last"}, px_last, 0);
    check({p, "_px_sof"}, px_sof, 0);
    check({p, "_px_data"}, px_data, 0);
    check({p, "_cur_y"}, cur_y, 0);
    check({p, "_cur_zoom"}, cur_zoom, 0);
    check({p, "_cur_real"}, cur_real_center, 0);
    check({p, "_cur_imag"}, cur_imag_center, 0);
  endtask

  task automatic cfg_pulse(logic [7:0] z, logic [WL-1:0] re, logic [WL-1:0] im);
    cfg_valid       = 1'b1;
    cfg_zoom        = z;
    cfg_real_center = re;
    cfg_imag_center = im;
    tick();
    cfg_valid = 1'b0;
  endtask

  int s0;
  int f0;
  int b0;
  int sf0;

  initial begin
    repeat (3) tick();
    check_zero("rst");
    reset = 1'b0;
    tick();

    // single frame, ready held high
    rdy_mode = 1;
    enable   = 1'b1;
    wait_starts(1, 20, "t1_first_start");
    enable = 1'b0;
    wait_frames(1, 400, "t1_frame_done");
    repeat (20) tick();
    check("t1_starts", starts, 4);
    check("t1_beats", beats, 32);
    check("t1_sofs", sofs, 1);
    check("t1_lasts", lasts, 4);
    check("t1_sb_empty", exp_q.size(), 0);

    // stream back-pressure during line 0: calc must stall after line 1
    rdy_mode = 0;
    enable   = 1'b1;
    repeat (40) tick();
    check("t2_stall_starts", starts, 6);
    check("t2_cur_y", cur_y, 1);
    check("t2_valid_held", px_valid, 1);
    enable   = 1'b0;
    rdy_mode = 1;
    wait_frames(2, 400, "t2_frame_done");
    repeat (20) tick();
    check("t2_starts", starts, 8);
    check("t2_beats", beats, 64);
    check("t2_sb_empty", exp_q.size(), 0);

    // cfg changes mid-frame take effect at the next frame start only
    enable = 1'b1;
    wait_starts(10, 60, "t3_mid_frame");
    cfg_pulse(8'd3, 32'h0000_0003, 32'h0000_0033);
    check("t3_zoom_hold_a", cur_zoom, 0);
    repeat (5) tick();
    cfg_pulse(8'd5, 32'h1234_5678, 32'hcafe_0001);
    check("t3_zoom_hold_b", cur_zoom, 0);
    check("t3_real_hold", cur_real_center, 0);
    wait_starts(13, 200, "t3_next_frame");
    check("t3_zoom_new", cur_zoom, 5);
    check("t3_real_new", cur_real_center, 32'h1234_5678);
    check("t3_imag_new", cur_imag_center, 32'hcafe_0001);
    cfg_pulse(8'd9, 32'h0000_0009, 32'h0000_0099);
    check("t3_zoom_hold_c", cur_zoom, 5);
    enable = 1'b0;
    wait_frames(4, 400, "t3_frame_done");
    repeat (20) tick();

    // reset in the middle of line 2 abandons the frame and the pending cfg
    enable = 1'b1;
    wait_starts(19, 200, "t4_line2");
    repeat (6) tick();
    abort = 1'b1;
    reset = 1'b1;
    tick();
    exp_q.delete();
    check_zero("t4_rst");
    reset  = 1'b0;
    enable = 1'b0;
    repeat (40) tick();
    abort = 1'b0;
    ey    = 0;

    // three frames with random back-pressure after reset
    s0  = starts;
    f0  = frames;
    b0  = beats;
    sf0 = sofs;
    rdy_mode = 2;
    enable   = 1'b1;
    wait_starts(s0 + 1, 40, "t5_first_start");
    check("t5_pending_cleared", cur_zoom, 0);
    wait_starts(s0 + 9, 1500, "t5_third_frame");
    enable = 1'b0;
    wait_frames(f0 + 3, 2000, "t5_frame_done");
    repeat (30) tick();
    check("t5_starts", starts - s0, 12);
    check("t5_beats", beats - b0, 96);
    check("t5_sofs", sofs - sf0, 3);
    check("t5_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
